// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer
// and synchronous flush. An empty stage presents an all-zero payload downstream.
module pipe_stage_skid #(
  parameter int DATA_W           = 133,
  parameter int PC_W             = 32,
  parameter bit KEEP_PC_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic push, pop;

  // in_ready depends only on registered state, so out_ready never reaches upstream combinationally
  assign in_ready  = !reset && !skid_v_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = main_v_q && out_ready;

  assign out_valid = main_v_q;
  assign out_pc    = main_pc_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d    = main_v_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_data_d = '0;
      main_pc_d   = KEEP_PC_ON_FLUSH ? in_pc : '0;
    end else if (skid_v_q) begin
      if (pop) begin
        main_pc_d   = skid_pc_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q || pop) begin
        main_v_d    = 1'b1;
        main_pc_d   = in_pc;
        main_data_d = in_data;
      end else begin
        skid_v_d    = 1'b1;
        skid_pc_d   = in_pc;
        skid_data_d = in_data;
      end
    end else if (pop) begin
      // PC is kept so a later flush/exception still sees the last retired beat's PC
      main_v_d    = 1'b0;
      main_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_v_q    <= 1'b0;
      main_pc_q   <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Two stages (8-bit payload keeping PC on flush, 165-bit payload clearing it) driven in
// lockstep and compared every cycle against a queue of beats held by the stage.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_pc;
  logic [164:0] in_data;
  logic         flush;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0]  out_pc_a, out_pc_b;
  logic [7:0]   out_data_a;
  logic [164:0] out_data_b;
  logic [1:0]   occ_a, occ_b;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(8), .PC_W(32), .KEEP_PC_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pc(in_pc), .in_data(in_data[7:0]), .flush(flush), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_pc(out_pc_a), .out_data(out_data_a), .occupancy(occ_a));

  pipe_stage_skid #(.DATA_W(165), .PC_W(32), .KEEP_PC_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_data(in_data), .flush(flush), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_pc(out_pc_b), .out_data(out_data_b), .occupancy(occ_b));

  typedef struct {
    logic [31:0]  pc;
    logic [164:0] data;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] pc_a_exp, pc_b_exp;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [164:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Scoreboard update with the inputs present at the active edge
  task automatic model_edge();
    beat_t b;
    logic  do_pop, do_push;
    if (reset) begin
      sb.delete();
      pc_a_exp = '0;
      pc_b_exp = '0;
    end else if (flush) begin
      sb.delete();
      pc_a_exp = in_pc;
      pc_b_exp = '0;
    end else begin
      do_pop  = (sb.size() > 0) && out_ready;
      do_push = in_valid && (sb.size() < 2);
      if (do_pop) begin
        b = sb.pop_front();
        pc_a_exp = b.pc;
        pc_b_exp = b.pc;
      end
      if (do_push) begin
        b.pc   = in_pc;
        b.data = in_data;
        sb.push_back(b);
      end
      if (sb.size() > 0) begin
        pc_a_exp = sb[0].pc;
        pc_b_exp = sb[0].pc;
      end
    end
  endtask

  task automatic check_all();
    logic         nonempty;
    logic [164:0] d;
    nonempty = (sb.size() > 0);
    d = nonempty ? sb[0].data : '0;
    chk("a.in_ready",  256'(in_ready_a),  256'(!reset && sb.size() < 2));
    chk("a.out_valid", 256'(out_valid_a), 256'(nonempty));
    chk("a.occupancy", 256'(occ_a),       256'(sb.size()));
    chk("a.out_pc",    256'(out_pc_a),    256'(pc_a_exp));
    chk("a.out_data",  256'(out_data_a),  256'(d[7:0]));
    chk("b.in_ready",  256'(in_ready_b),  256'(!reset && sb.size() < 2));
    chk("b.out_valid", 256'(out_valid_b), 256'(nonempty));
    chk("b.occupancy", 256'(occ_b),       256'(sb.size()));
    chk("b.out_pc",    256'(out_pc_b),    256'(pc_b_exp));
    chk("b.out_data",  256'(out_data_b),  256'(d));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [191:0] r;
    sb.delete();
    pc_a_exp = '0;
    pc_b_exp = '0;

    // reset with a beat offered upstream
    reset = 1'b1;
    drive(1'b1, 32'h0, '1, 1'b0, 1'b0);
    cycle();
    cycle();
    chk("rst.in_ready_a", 256'(in_ready_a), 256'(0));
    chk("rst.in_ready_b", 256'(in_ready_b), 256'(0));
    reset = 1'b0;
    drive(1'b0, 32'h0, '1, 1'b0, 1'b0);
    cycle();
    chk("post_rst.out_valid", 256'(out_valid_a), 256'(0));
    chk("post_rst.out_data",  256'(out_data_b),  256'(0));
    chk("post_rst.out_pc",    256'(out_pc_a),    256'(0));
    chk("post_rst.occ",       256'(occ_b),       256'(0));
    chk("post_rst.in_ready",  256'(in_ready_a),  256'(1));

    // streaming at full rate
    drive(1'b1, 32'h3000, 165'h11, 1'b1, 1'b0); cycle();
    chk("stream.pc0", 256'(out_pc_a), 256'(32'h3000));
    drive(1'b1, 32'h3004, 165'h22, 1'b1, 1'b0); cycle();
    chk("stream.pc1", 256'(out_pc_b), 256'(32'h3004));
    drive(1'b1, 32'h3008, 165'h33, 1'b1, 1'b0); cycle();
    chk("stream.pc2", 256'(out_pc_a), 256'(32'h3008));
    chk("stream.occ", 256'(occ_a), 256'(1));
    drive(1'b0, 32'h0, '0, 1'b1, 1'b0); cycle();

    // backpressure into the skid entry
    drive(1'b1, 32'h3000, 165'h44, 1'b1, 1'b0); cycle();
    drive(1'b1, 32'h3004, 165'h55, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h3008, 165'h66, 1'b0, 1'b0); cycle();
    cycle();
    chk("bp.occ",      256'(occ_a),      256'(2));
    chk("bp.in_ready", 256'(in_ready_b), 256'(0));
    chk("bp.main_pc",  256'(out_pc_a),   256'(32'h3000));
    drive(1'b1, 32'h3008, 165'h66, 1'b1, 1'b0); cycle();
    chk("bp.drain1", 256'(out_pc_a), 256'(32'h3004));
    cycle();
    chk("bp.drain2", 256'(out_pc_b), 256'(32'h3008));
    chk("bp.data2",  256'(out_data_b), 256'(165'h66));
    drive(1'b0, 32'h0, '0, 1'b1, 1'b0); cycle();

    // flush while full
    drive(1'b1, 32'h3020, 165'h77, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h3024, 165'h88, 1'b0, 1'b0); cycle();
    chk("fl.occ_before", 256'(occ_a), 256'(2));
    drive(1'b1, 32'h3010, 165'h99, 1'b0, 1'b1); cycle();
    chk("fl.out_valid", 256'(out_valid_a), 256'(0));
    chk("fl.out_data",  256'(out_data_a),  256'(0));
    chk("fl.keep_pc",   256'(out_pc_a),    256'(32'h3010));
    chk("fl.clear_pc",  256'(out_pc_b),    256'(0));
    chk("fl.occ",       256'(occ_b),       256'(0));

    // drain a single beat with nothing behind it
    drive(1'b1, 32'h3000, 165'hABCD, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, '0, 1'b1, 1'b0); cycle();
    chk("drain.out_valid", 256'(out_valid_b), 256'(0));
    chk("drain.out_data",  256'(out_data_b),  256'(0));
    chk("drain.pc_a",      256'(out_pc_a),    256'(32'h3000));
    chk("drain.pc_b",      256'(out_pc_b),    256'(32'h3000));

    // random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      reset = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 9) < 7, $urandom(), r[164:0],
            $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
